tdm_demux4b_1_to_4: RTL and testbench



---
 rtl/tdm_demux4b_1_to_4.sv | 125 ++++++++++++
 tb/tb_tdm_demux4b_1_to_4.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4b_1_to_4.sv
// TDM receive demux: locks onto the lane-a sync flag and collects four beats into
// a frame that is presented atomically on out_a..out_d with a one-cycle frame_valid.
module tdm_demux4b_1_to_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_sync,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic             frame_valid,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [1:0]       r_slot;
  logic [1:0]       w_slot_n;
  logic             r_frame_valid;
  logic             r_sync_err;
  logic             w_ld0;
  logic             w_ldn;
  logic             w_emit;
  logic             w_err;
  logic [WIDTH-1:0] r_sh0;
  logic [WIDTH-1:0] r_sh1;
  logic [WIDTH-1:0] r_sh2;
  logic [WIDTH-1:0] r_out_a;
  logic [WIDTH-1:0] r_out_b;
  logic [WIDTH-1:0] r_out_c;
  logic [WIDTH-1:0] r_out_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= HUNT;
      r_slot        <= 2'd0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_slot        <= w_slot_n;
      r_frame_valid <= w_emit;
      r_sync_err    <= w_err;
    end
  end

  // A sync beat always restarts the frame; it is an error only if a frame was in progress.
  always_comb begin
    w_state_n = r_state;
    w_slot_n  = r_slot;
    w_ld0     = 1'b0;
    w_ldn     = 1'b0;
    w_emit    = 1'b0;
    w_err     = 1'b0;
    if (in_valid) begin
      case (r_state)
        HUNT: begin
          if (in_sync) begin
            w_ld0     = 1'b1;
            w_slot_n  = 2'd1;
            w_state_n = LOCK;
          end
        end
        LOCK: begin
          if (in_sync) begin
            w_ld0    = 1'b1;
            w_slot_n = 2'd1;
            w_err    = (r_slot != 2'd0);
          end else if (r_slot == 2'd0) begin
            w_err     = 1'b1;
            w_slot_n  = 2'd0;
            w_state_n = HUNT;
          end else if (r_slot == 2'd3) begin
            w_emit   = 1'b1;
            w_slot_n = 2'd0;
          end else begin
            w_ldn    = 1'b1;
            w_slot_n = r_slot + 2'd1;
          end
        end
        default: w_state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh0   <= '0;
      r_sh1   <= '0;
      r_sh2   <= '0;
      r_out_a <= '0;
      r_out_b <= '0;
      r_out_c <= '0;
      r_out_d <= '0;
    end else begin
      if (w_ld0) r_sh0 <= in_data;
      if (w_ldn && r_slot == 2'd1) r_sh1 <= in_data;
      if (w_ldn && r_slot == 2'd2) r_sh2 <= in_data;
      if (w_emit) begin
        r_out_a <= r_sh0;
        r_out_b <= r_sh1;
        r_out_c <= r_sh2;
        r_out_d <= in_data;
      end
    end
  end

  assign out_a       = r_out_a;
  assign out_b       = r_out_b;
  assign out_c       = r_out_c;
  assign out_d       = r_out_d;
  assign frame_valid = r_frame_valid;
  assign slot        = r_slot;
  assign locked      = (r_state == LOCK);
  assign sync_err    = r_sync_err;

endmodule

// File: tb/tb_tdm_demux4b_1_to_4.sv
// Bench for tdm_demux4b_1_to_4: directed framing scenarios plus random beats,
// compared every cycle against a queue-based frame model.
module tb_tdm_demux4b_1_to_4;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_sync;
  logic [3:0] in_data;
  logic [3:0] out_a, out_b, out_c, out_d;
  logic       frame_valid;
  logic [1:0] slot;
  logic       locked;
  logic       sync_err;

  int checks   = 0;
  int failures = 0;

  // model state: a frame in progress is just the list of beats collected so far
  logic [3:0] mpart[$];
  bit         mlock;
  logic [3:0] ea, eb, ec, ed;
  logic       efv, eerr;

  tdm_demux4b_1_to_4 #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sync(in_sync),
    .in_data(in_data), .out_a(out_a), .out_b(out_b), .out_c(out_c),
    .out_d(out_d), .frame_valid(frame_valid), .slot(slot), .locked(locked),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mpart.delete();
    mlock = 1'b0;
    {ea, eb, ec, ed} = 16'h0;
    efv  = 1'b0;
    eerr = 1'b0;
  endtask

  task automatic model_beat(input logic v, input logic s, input logic [3:0] d);
    efv  = 1'b0;
    eerr = 1'b0;
    if (v) begin
      if (!mlock) begin
        if (s) begin
          mpart = {d};
          mlock = 1'b1;
        end
      end else if (s) begin
        eerr  = (mpart.size() != 0);
        mpart = {d};
      end else if (mpart.size() == 0) begin
        eerr  = 1'b1;
        mlock = 1'b0;
      end else begin
        mpart.push_back(d);
        if (mpart.size() == 4) begin
          ea = mpart[0]; eb = mpart[1]; ec = mpart[2]; ed = mpart[3];
          efv = 1'b1;
          mpart.delete();
        end
      end
    end
  endtask

  function automatic logic [20:0] expected();
    logic [1:0] es;
    es = mlock ? 2'(mpart.size()) : 2'd0;
    return {ea, eb, ec, ed, efv, es, mlock, eerr};
  endfunction

  function automatic logic [20:0] observed();
    return {out_a, out_b, out_c, out_d, frame_valid, slot, locked, sync_err};
  endfunction

  task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic v, input logic s, input logic [3:0] d, input string tag);
    in_valid = v;
    in_sync  = s;
    in_data  = d;
    model_beat(v, s, d);
    @(posedge clk);
    #1;
    check(tag, observed(), expected());
  endtask

  task automatic frame(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] d, input int gap, input string tag);
    logic [3:0] bt[4];
    bt = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, i == 0, bt[i], tag);
      if (i < 3) for (int g = 0; g < gap; g++) beat(1'b0, 1'b0, 4'h0, {tag, "_gap"});
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sync = 1'b0; in_data = 4'h0;
    model_reset();
    #2;
    check("reset_state", observed(), 21'h0);
    #10;
    reset = 1'b0;

    // single frame
    frame(4'h5, 4'hA, 4'hC, 4'h3, 0, "single");
    check("single_const", observed(), {16'h5AC3, 1'b1, 2'd0, 1'b1, 1'b0});
    beat(1'b0, 1'b0, 4'h0, "single_after");
    check("single_pulse_once", {31'b0, frame_valid}, 32'd0);

    // continuous stream of three frames
    for (int f = 0; f < 3; f++)
      frame(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 0, "continuous");

    // gapped beats, outputs hold previous frame until the last beat
    frame(4'h5, 4'hA, 4'hC, 4'h3, 2, "gapped");
    check("gapped_const", observed(), {16'h5AC3, 1'b1, 2'd0, 1'b1, 1'b0});

    // early sync
    beat(1'b1, 1'b1, 4'hF, "early");
    beat(1'b1, 1'b0, 4'h1, "early");
    beat(1'b1, 1'b1, 4'h2, "early_sync");
    check("early_err_const", {31'b0, sync_err}, 32'd1);
    beat(1'b1, 1'b0, 4'h4, "early");
    beat(1'b1, 1'b0, 4'h8, "early");
    beat(1'b1, 1'b0, 4'h0, "early_frame");
    check("early_const", observed(), {16'h2480, 1'b1, 2'd0, 1'b1, 1'b0});

    // missing sync after the good frame
    beat(1'b1, 1'b0, 4'h7, "missing_sync");
    check("missing_const", {30'b0, locked, sync_err}, 32'd1);
    for (int i = 0; i < 3; i++) beat(1'b1, 1'b0, 4'($urandom), "hunt_ignore");
    frame(4'h9, 4'h6, 4'hE, 4'hB, 1, "relock");
    check("relock_const", observed(), {16'h96EB, 1'b1, 2'd0, 1'b1, 1'b0});

    // random beats with occasional framing errors and gaps
    for (int i = 0; i < 400; i++) begin
      logic v, s;
      v = ($urandom_range(0, 3) != 0);
      s = (mpart.size() == 0) ^ ($urandom_range(0, 15) == 0);
      beat(v, s, 4'($urandom), "random");
    end

    // reset asserted mid-frame while waiting for slot 2
    frame(4'h1, 4'h2, 4'h3, 4'h4, 0, "pre_reset");
    beat(1'b1, 1'b1, 4'hD, "pre_reset");
    beat(1'b1, 1'b0, 4'hE, "pre_reset");
    in_valid = 1'b1; in_sync = 1'b0; in_data = 4'hF;
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check("reset_async", observed(), 21'h0);
    @(posedge clk);
    #1;
    check("reset_hold", observed(), 21'h0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) beat(1'b1, 1'b0, 4'($urandom), "post_reset_ignore");
    frame(4'hC, 4'h0, 4'hF, 4'hE, 0, "post_reset_frame");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
